// File: rtl/dm_stage_pipe.sv
// rtl/dm_stage_pipe.sv - data-memory stage between EX and WB with handshake, RAM clear and range check
// Optional per-byte store enables are compiled in when DM_BYTE_WE_EN is defined.
module dm_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    output logic              ready_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] dm_data,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_mux_sel_dm,
`ifdef DM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] byte_en,
`endif
    output logic              valid_dm,
    input  logic              ready_wb,
    output logic [DATA_W-1:0] ans_dm,
    output logic              addr_err_dm,
    output logic              init_done
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] ans_q, ans_d;
    logic              err_q, err_d;
    logic              sel_q, sel_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] addr;
    logic              oob;
    logic              accept;
    logic              do_wr;
    logic              do_rd;

    assign addr = ans_ex[ADDR_W-1:0];

    generate
        if (DATA_W > ADDR_W) begin : g_oob
            assign oob = mem_en_ex && (ans_ex[DATA_W-1:ADDR_W] != '0);
        end else begin : g_no_oob
            assign oob = 1'b0;
        end
    endgenerate

    assign ready_ex = (state_q == ST_RUN) && (!valid_q || ready_wb);
    assign accept   = valid_ex && ready_ex;
    assign do_wr    = accept && mem_en_ex && mem_rw_ex && !oob;
    assign do_rd    = accept && mem_en_ex && !mem_rw_ex && !oob;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        valid_d     = valid_q;
        ans_d       = ans_q;
        err_d       = err_q;
        sel_d       = sel_q;
        load_d      = load_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
        if (accept) begin
            valid_d = 1'b1;
            ans_d   = ans_ex;
            err_d   = oob;
            sel_d   = mem_mux_sel_dm;
            load_d  = mem_en_ex && !mem_rw_ex && !oob;
        end else if (ready_wb) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            valid_q     <= 1'b0;
            ans_q       <= '0;
            err_q       <= 1'b0;
            sel_q       <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            valid_q     <= valid_d;
            ans_q       <= ans_d;
            err_q       <= err_d;
            sel_q       <= sel_d;
            load_q      <= load_d;
        end
    end

    // RAM contents are not reset; the INIT sweep clears them instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q] <= '0;
            end else if (do_wr) begin
`ifdef DM_BYTE_WE_EN
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (byte_en[b]) begin
                        mem[addr][b*8 +: 8] <= dm_data[b*8 +: 8];
                    end
                end
`else
                mem[addr] <= dm_data;
`endif
            end
            if (do_rd) begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign valid_dm    = valid_q;
    assign addr_err_dm = err_q;
    assign init_done   = init_done_q;
    assign ans_dm      = sel_q ? (load_q ? rdata_q : '0) : ans_q;

endmodule

// File: tb/tb_dm_stage_pipe.sv
// tb/tb_dm_stage_pipe.sv - directed self-checking bench for dm_stage_pipe
module tb_dm_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic [15:0] ans_ex;
    logic [15:0] dm_data;
    logic        mem_en_ex;
    logic        mem_rw_ex;
    logic        mem_mux_sel_dm;
    logic        ready_wb;
`ifdef DM_BYTE_WE_EN
    logic [1:0]  byte_en;
`endif

    logic        ready8, valid8, err8, init8;
    logic [15:0] ans8;
    logic        ready4, valid4, err4, init4;
    logic [15:0] ans4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dm_stage_pipe #(.DATA_W(16), .ADDR_W(8)) dut8 (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .ready_ex(ready8),
        .ans_ex(ans_ex), .dm_data(dm_data), .mem_en_ex(mem_en_ex),
        .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
`ifdef DM_BYTE_WE_EN
        .byte_en(byte_en),
`endif
        .valid_dm(valid8), .ready_wb(ready_wb), .ans_dm(ans8),
        .addr_err_dm(err8), .init_done(init8)
    );

    dm_stage_pipe #(.DATA_W(16), .ADDR_W(4)) dut4 (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .ready_ex(ready4),
        .ans_ex(ans_ex), .dm_data(dm_data), .mem_en_ex(mem_en_ex),
        .mem_rw_ex(mem_rw_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
`ifdef DM_BYTE_WE_EN
        .byte_en(byte_en),
`endif
        .valid_dm(valid4), .ready_wb(ready_wb), .ans_dm(ans4),
        .addr_err_dm(err4), .init_done(init4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                         input logic en, input logic rw, input logic sel);
        valid_ex       = v;
        ans_ex         = a;
        dm_data        = d;
        mem_en_ex      = en;
        mem_rw_ex      = rw;
        mem_mux_sel_dm = sel;
        #1;
    endtask

    task automatic wait_init8();
        for (int i = 0; i < 300 && !init8; i++) tick();
        chk("init8_done", init8, 1);
    endtask

    initial begin
        reset    = 1'b0;
        ready_wb = 1'b1;
`ifdef DM_BYTE_WE_EN
        byte_en  = 2'b11;
`endif
        drive(0, 16'h0, 16'h0, 0, 0, 0);
        tick();
        tick();
        chk("rst_valid", valid8, 0);
        chk("rst_ans", ans8, 16'h0);
        chk("rst_err", err8, 0);
        chk("rst_init", init8, 0);
        chk("rst_ready", ready8, 0);

        reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("init4_ready_%0d", i), ready4, 0);
            tick();
        end
        chk("init4_ready_after", ready4, 1);
        chk("init4_done", init4, 1);

        // ADDR_W=4 instance accepts this load; the ADDR_W=8 instance is still clearing
        drive(1, 16'h0005, 16'h0, 1, 0, 1);
        tick();
        chk("ld5_valid4", valid4, 1);
        chk("ld5_ans4", ans4, 16'h0000);
        chk("init8_still_busy", ready8, 0);
        drive(0, 16'h0, 16'h0, 0, 0, 0);

        wait_init8();
        chk("run_ready8", ready8, 1);

        drive(1, 16'h000A, 16'hBEEF, 1, 1, 0);
        tick();
        chk("st_valid", valid8, 1);
        chk("st_ans", ans8, 16'h000A);
        chk("st_err", err8, 0);
        drive(1, 16'h000A, 16'h0, 1, 0, 1);
        tick();
        chk("ld_fwd_ans", ans8, 16'hBEEF);
        chk("ld_fwd_valid", valid8, 1);

        ready_wb = 1'b0;
        drive(1, 16'h1234, 16'h0, 0, 0, 0);
        chk("stall_ready0", ready8, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_ans_%0d", i), ans8, 16'hBEEF);
            chk($sformatf("stall_valid_%0d", i), valid8, 1);
            chk($sformatf("stall_ready_%0d", i), ready8, 0);
        end
        ready_wb = 1'b1;
        #1;
        chk("unstall_ready", ready8, 1);
        tick();
        chk("alu_ans", ans8, 16'h1234);
        chk("alu_err", err8, 0);
        chk("alu_valid", valid8, 1);

        drive(1, 16'h0034, 16'h0, 1, 0, 1);
        tick();
        chk("alu_no_write", ans8, 16'h0000);

        drive(1, 16'h0005, 16'h5555, 1, 1, 0);
        tick();
        drive(1, 16'h0105, 16'h7777, 1, 1, 0);
        tick();
        chk("oob_st_err", err8, 1);
        chk("oob_st_ans", ans8, 16'h0105);
        drive(1, 16'h0005, 16'h0, 1, 0, 1);
        tick();
        chk("oob_keep_ans", ans8, 16'h5555);
        chk("oob_keep_err", err8, 0);
        drive(1, 16'h0205, 16'h0, 1, 0, 1);
        tick();
        chk("oob_ld_ans", ans8, 16'h0000);
        chk("oob_ld_err", err8, 1);
        drive(1, 16'h0006, 16'h9999, 1, 1, 1);
        tick();
        chk("st_sel1_ans", ans8, 16'h0000);

        drive(0, 16'h0, 16'h0, 0, 0, 0);
        tick();
        chk("drain_valid", valid8, 0);

        drive(1, 16'h000A, 16'h0, 1, 0, 1);
        tick();
        ready_wb = 1'b0;
        drive(0, 16'h0, 16'h0, 0, 0, 0);
        chk("pre_rst_valid", valid8, 1);
        chk("pre_rst_ans", ans8, 16'hBEEF);
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", valid8, 0);
        chk("mid_rst_ans", ans8, 16'h0000);
        chk("mid_rst_init", init8, 0);
        chk("mid_rst_ready", ready8, 0);
        reset    = 1'b1;
        ready_wb = 1'b1;
        #1;
        wait_init8();

        drive(1, 16'h000A, 16'h0, 1, 0, 1);
        tick();
        chk("reinit_cleared", ans8, 16'h0000);

`ifdef DM_BYTE_WE_EN
        byte_en = 2'b11;
        drive(1, 16'h0020, 16'h1111, 1, 1, 0);
        tick();
        byte_en = 2'b10;
        drive(1, 16'h0020, 16'hAB00, 1, 1, 0);
        tick();
        byte_en = 2'b00;
        drive(1, 16'h0020, 16'hFFFF, 1, 1, 0);
        tick();
        chk("be0_completes", valid8, 1);
        byte_en = 2'b11;
        drive(1, 16'h0020, 16'h0, 1, 0, 1);
        tick();
        chk("be_merge", ans8, 16'hAB11);
`endif

        drive(0, 16'h0, 16'h0, 0, 0, 0);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
